// File: rtl/alu_station_pkg.sv
// Shared types and constants for the ALU reservation station.
// Holds word/address/tag/register/op types, the tag constants, the ALU op
// codes, the station state encoding, and the operand wakeup helper.
package alu_station_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned REGTAG_W  = 2;
  localparam int unsigned REGADDR_W = 5;
  localparam int unsigned SINST_W   = 4;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned NBUS      = 3;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [WORD_W-1:0]    addr_t;
  typedef logic [REGTAG_W-1:0]  regtag_t;
  typedef logic [REGADDR_W-1:0] regaddr_t;
  typedef logic [SINST_W-1:0]   sinst_t;

  localparam regtag_t UNLOCKED   = 2'b00;
  localparam regtag_t ALU_MASTER = 2'b01;
  localparam regtag_t ALU_SALVER = 2'b10;
  localparam regtag_t LOAD_STORE = 2'b11;

  localparam sinst_t OP_ADD   = 4'h0;
  localparam sinst_t OP_SUB   = 4'h1;
  localparam sinst_t OP_SLL   = 4'h2;
  localparam sinst_t OP_SLT   = 4'h3;
  localparam sinst_t OP_SLTU  = 4'h4;
  localparam sinst_t OP_XOR   = 4'h5;
  localparam sinst_t OP_SRL   = 4'h6;
  localparam sinst_t OP_SRA   = 4'h7;
  localparam sinst_t OP_OR    = 4'h8;
  localparam sinst_t OP_AND   = 4'h9;
  localparam sinst_t OP_LUI   = 4'hA;
  localparam sinst_t OP_AUIPC = 4'hB;
  localparam sinst_t OP_LINK  = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BCAST = 2'd2
  } state_t;

  typedef struct packed {
    regtag_t tag;
    word_t   data;
  } operand_t;

  // Resolve a locked operand from whichever snooped write-back bus carries its tag.
  function automatic operand_t wake(input operand_t opnd, input logic [NBUS-1:0] en_mw,
                                    input word_t d0, input word_t d1, input word_t d2);
    operand_t res;
    res = opnd;
    case (opnd.tag)
      ALU_MASTER: if (en_mw[0]) res = '{tag: UNLOCKED, data: d0};
      ALU_SALVER: if (en_mw[1]) res = '{tag: UNLOCKED, data: d1};
      LOAD_STORE: if (en_mw[2]) res = '{tag: UNLOCKED, data: d2};
      default:    res = opnd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_station_alu_core.sv
// alu_core: purely combinational integer ALU for the reservation station.
// Ports: op (sub-op), pc (instruction PC), x/y (operands) -> result_c.
// Ops 0xD-0xF produce zero; all arithmetic wraps modulo 2^32.
module alu_core
  import alu_station_pkg::*;
(
  input  logic [SINST_W-1:0] op,
  input  logic [WORD_W-1:0]  pc,
  input  logic [WORD_W-1:0]  x,
  input  logic [WORD_W-1:0]  y,
  output logic [WORD_W-1:0]  result_c
);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = y[SHAMT_W-1:0];

  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:   result_c = x + y;
      OP_SUB:   result_c = x - y;
      OP_SLL:   result_c = x << shamt;
      OP_SLT:   result_c = WORD_W'($signed(x) < $signed(y));
      OP_SLTU:  result_c = WORD_W'(x < y);
      OP_XOR:   result_c = x ^ y;
      OP_SRL:   result_c = x >> shamt;
      OP_SRA:   result_c = WORD_W'($signed(x) >>> shamt);
      OP_OR:    result_c = x | y;
      OP_AND:   result_c = x & y;
      OP_LUI:   result_c = y;
      OP_AUIPC: result_c = pc + y;
      OP_LINK:  result_c = pc + WORD_W'(4);
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_station.sv
// alu_station: single-entry ALU reservation station.
// Captures an issued instruction, snoops three write-back buses to wake
// locked operands, computes the result via alu_core and broadcasts it on its
// own write-back bus for exactly one cycle.
// Ports: clk, rst (async active-low), rdy (global enable), issue inputs
// (en_in, pc_in, op_in, tagx/y_in, datax/y_in, tagw_in, addrw_in), snooped
// buses (en_mw0..2, write_data0..2), flush_in; outputs busy_out, en_mw_out,
// reg_write_addr_out, write_data_out.
// Build option: define ALU_STATION_FORWARD_EN to let operands that are ready
// at capture (or woken on the deciding edge) go straight to broadcast.
module alu_station
  import alu_station_pkg::*;
#(
  parameter regtag_t MY_TAG = ALU_MASTER
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 en_in,
  input  logic [WORD_W-1:0]    pc_in,
  input  logic [SINST_W-1:0]   op_in,
  input  logic [REGTAG_W-1:0]  tagx_in,
  input  logic [REGTAG_W-1:0]  tagy_in,
  input  logic [WORD_W-1:0]    datax_in,
  input  logic [WORD_W-1:0]    datay_in,
  input  logic [REGTAG_W-1:0]  tagw_in,
  input  logic [REGADDR_W-1:0] addrw_in,
  input  logic                 en_mw0,
  input  logic                 en_mw1,
  input  logic                 en_mw2,
  input  logic [WORD_W-1:0]    write_data0,
  input  logic [WORD_W-1:0]    write_data1,
  input  logic [WORD_W-1:0]    write_data2,
  input  logic                 flush_in,
  output logic                 busy_out,
  output logic                 en_mw_out,
  output logic [REGADDR_W-1:0] reg_write_addr_out,
  output logic [WORD_W-1:0]    write_data_out
);

  state_t   state, state_nx;
  addr_t    pc_q, pc_nx;
  sinst_t   op_q, op_nx;
  regaddr_t addr_q, addr_nx;
  operand_t opx_q, opx_nx, opy_q, opy_nx;
  logic     en_nx;
  regaddr_t waddr_nx;
  word_t    wdata_nx;

  addr_t    src_pc;
  sinst_t   src_op;
  regaddr_t src_addr;
  operand_t src_x, src_y, wx, wy;
  word_t    alu_res_c;
  logic     go_c;
  logic     load_out;

  // Tag of the broadcast bus and the destination tag are informational only.
  logic unused_dbg;
  assign unused_dbg = ^{tagw_in, MY_TAG};

  // In IDLE the candidate instruction comes from the issue port, otherwise from the latch.
  always_comb begin
    src_pc   = pc_q;
    src_op   = op_q;
    src_addr = addr_q;
    src_x    = opx_q;
    src_y    = opy_q;
    if (state == ST_IDLE) begin
      src_pc   = pc_in;
      src_op   = op_in;
      src_addr = addrw_in;
      src_x    = '{tag: tagx_in, data: datax_in};
      src_y    = '{tag: tagy_in, data: datay_in};
    end
  end

  assign wx = wake(src_x, {en_mw2, en_mw1, en_mw0}, write_data0, write_data1, write_data2);
  assign wy = wake(src_y, {en_mw2, en_mw1, en_mw0}, write_data0, write_data1, write_data2);

  alu_core u_alu_core (
    .op       (src_op),
    .pc       (src_pc),
    .x        (wx.data),
    .y        (wy.data),
    .result_c (alu_res_c)
  );

  // Readiness test: forwarding looks at this edge's wakeups, otherwise only latched tags.
`ifdef ALU_STATION_FORWARD_EN
  assign go_c = (wx.tag == UNLOCKED) && (wy.tag == UNLOCKED);
`else
  assign go_c = (opx_q.tag == UNLOCKED) && (opy_q.tag == UNLOCKED);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    op_nx    = op_q;
    addr_nx  = addr_q;
    opx_nx   = opx_q;
    opy_nx   = opy_q;
    load_out = 1'b0;
    en_nx    = 1'b0;
    waddr_nx = reg_write_addr_out;
    wdata_nx = write_data_out;

    if (flush_in) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_in) begin
            pc_nx   = pc_in;
            op_nx   = op_in;
            addr_nx = addrw_in;
            opx_nx  = wx;
            opy_nx  = wy;
`ifdef ALU_STATION_FORWARD_EN
            if (go_c) begin
              state_nx = ST_BCAST;
              load_out = 1'b1;
            end else begin
              state_nx = ST_WAIT;
            end
`else
            state_nx = ST_WAIT;
`endif
          end
        end
        ST_WAIT: begin
          opx_nx = wx;
          opy_nx = wy;
          if (go_c) begin
            state_nx = ST_BCAST;
            load_out = 1'b1;
          end
        end
        ST_BCAST: state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end

    // Register zero is never written, but the broadcast still happens.
    if (load_out) begin
      en_nx    = 1'b1;
      waddr_nx = src_addr;
      wdata_nx = (src_addr == '0) ? '0 : alu_res_c;
    end
  end

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_IDLE;
      pc_q               <= '0;
      op_q               <= '0;
      addr_q             <= '0;
      opx_q              <= '0;
      opy_q              <= '0;
      busy_out           <= 1'b0;
      en_mw_out          <= 1'b0;
      reg_write_addr_out <= '0;
      write_data_out     <= '0;
    end else if (rdy) begin
      state              <= state_nx;
      pc_q               <= pc_nx;
      op_q               <= op_nx;
      addr_q             <= addr_nx;
      opx_q              <= opx_nx;
      opy_q              <= opy_nx;
      busy_out           <= (state_nx != ST_IDLE);
      en_mw_out          <= en_nx;
      reg_write_addr_out <= waddr_nx;
      write_data_out     <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_alu_station.sv
// Self-checking bench for alu_station: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_alu_station;

`ifdef ALU_STATION_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, en_in, flush_in;
  logic [31:0] pc_in, datax_in, datay_in;
  logic [3:0]  op_in;
  logic [1:0]  tagx_in, tagy_in, tagw_in;
  logic [4:0]  addrw_in;
  logic        en_mw0, en_mw1, en_mw2;
  logic [31:0] write_data0, write_data1, write_data2;
  logic        busy_out, en_mw_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] write_data_out;

  int n_cmp, n_err;

  // transaction descriptor and bus event schedule (bus index, cycle)
  logic [3:0]  t_op;
  logic [31:0] t_pc, t_x, t_y;
  logic [1:0]  t_tx, t_ty;
  logic [4:0]  t_addr;
  logic        ev_en [3][8];
  logic [31:0] ev_d  [3][8];
  logic [4:0]  last_addr;
  logic [31:0] last_data;

  alu_station #(.MY_TAG(2'b01)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .en_in(en_in), .pc_in(pc_in), .op_in(op_in),
    .tagx_in(tagx_in), .tagy_in(tagy_in), .datax_in(datax_in), .datay_in(datay_in),
    .tagw_in(tagw_in), .addrw_in(addrw_in),
    .en_mw0(en_mw0), .en_mw1(en_mw1), .en_mw2(en_mw2),
    .write_data0(write_data0), .write_data1(write_data1), .write_data2(write_data2),
    .flush_in(flush_in), .busy_out(busy_out), .en_mw_out(en_mw_out),
    .reg_write_addr_out(reg_write_addr_out), .write_data_out(write_data_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    en_in = 1'b0; flush_in = 1'b0; rdy = 1'b1;
    en_mw0 = 1'b0; en_mw1 = 1'b0; en_mw2 = 1'b0;
    write_data0 = $urandom; write_data1 = $urandom; write_data2 = $urandom;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] x,
                       input logic [31:0] y, input logic [1:0] tx, input logic [1:0] ty,
                       input logic [4:0] addr);
    en_in = 1'b1; op_in = op; pc_in = pc; datax_in = x; datay_in = y;
    tagx_in = tx; tagy_in = ty; addrw_in = addr; tagw_in = 2'($urandom);
  endtask

  task automatic clr_ev();
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 8; c++) begin
        ev_en[b][c] = 1'b0;
        ev_d[b][c]  = 32'h0;
      end
  endtask

  // Architectural result of one ALU op.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] pc,
                                          input logic [31:0] x, input logic [31:0] y);
    int     sh;
    longint sx;
    sh = int'(y & 32'd31);
    sx = longint'($signed(x));
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x << sh;
      4'd3:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4:  return (x < y) ? 32'd1 : 32'd0;
      4'd5:  return x ^ y;
      4'd6:  return x >> sh;
      4'd7:  return 32'(sx >>> sh);
      4'd8:  return x | y;
      4'd9:  return x & y;
      4'd10: return y;
      4'd11: return pc + y;
      4'd12: return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  // Cycle (relative to issue) at which an operand becomes known, and its value.
  task automatic resolve(input logic [1:0] tag, input logic [31:0] data,
                         output int when, output logic [31:0] val);
    when = 0;
    val  = data;
    if (tag != 2'b00) begin
      when = 99;
      for (int c = 7; c >= 0; c--)
        if (ev_en[int'(tag) - 1][c]) begin
          when = c;
          val  = ev_d[int'(tag) - 1][c];
        end
    end
  endtask

  // Runs one transaction from an idle cycle through one idle cycle after its broadcast.
  task automatic run_txn(input string name, input bit junk);
    int rx, ry, bc;
    logic [31:0] vx, vy, res;
    resolve(t_tx, t_x, rx, vx);
    resolve(t_ty, t_y, ry, vy);
    bc  = ((rx > ry) ? rx : ry) + ((FWD != 0) ? 1 : 2);
    res = (t_addr == 5'd0) ? 32'd0 : ref_alu(t_op, t_pc, vx, vy);
    if (bc > 6) begin
      chk({name, "_sched"}, 32'(bc), 32'd6);
      bc = 6;
    end
    for (int c = 0; c <= bc + 1; c++) begin
      if (c == bc) begin
        last_addr = t_addr;
        last_data = res;
      end
      chk({name, "_en"},   32'(en_mw_out), 32'(c == bc));
      chk({name, "_busy"}, 32'(busy_out),  32'(c >= 1 && c <= bc));
      chk({name, "_addr"}, 32'(reg_write_addr_out), 32'(last_addr));
      chk({name, "_data"}, write_data_out, last_data);
      idle_inputs();
      if (c == 0) issue(t_op, t_pc, t_x, t_y, t_tx, t_ty, t_addr);
      else if (junk && c <= bc && ($urandom_range(0, 1) == 1))
        issue(4'($urandom), $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom), 5'($urandom));
      en_mw0 = ev_en[0][c]; if (ev_en[0][c]) write_data0 = ev_d[0][c];
      en_mw1 = ev_en[1][c]; if (ev_en[1][c]) write_data1 = ev_d[1][c];
      en_mw2 = ev_en[2][c]; if (ev_en[2][c]) write_data2 = ev_d[2][c];
      step();
    end
  endtask

  task automatic set_txn(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] x,
                         input logic [31:0] y, input logic [1:0] tx, input logic [1:0] ty,
                         input logic [4:0] addr);
    t_op = op; t_pc = pc; t_x = x; t_y = y; t_tx = tx; t_ty = ty; t_addr = addr;
  endtask

  initial begin
    int bc;
    n_cmp = 0; n_err = 0;
    last_addr = 5'd0; last_data = 32'd0;
    rst = 1'b0;
    idle_inputs();
    issue(4'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 5'd0);
    en_in = 1'b0;

    // reset values
    #3;
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_en",   32'(en_mw_out), 32'd0);
    chk("rst_addr", 32'(reg_write_addr_out), 32'd0);
    chk("rst_data", write_data_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // ready operands: 5 + 7 -> r3
    clr_ev();
    set_txn(4'd0, 32'h100, 32'd5, 32'd7, 2'b00, 2'b00, 5'd3);
    run_txn("add_ready", 1'b0);

    // x waits on load/store bus four cycles after issue: 10 - 1
    clr_ev();
    ev_en[2][4] = 1'b1; ev_d[2][4] = 32'd10;
    set_txn(4'd1, 32'h104, 32'hdead, 32'd1, 2'b11, 2'b00, 5'd4);
    run_txn("sub_wake", 1'b0);

    // x and y woken in the same cycle from different buses, signed compare
    clr_ev();
    ev_en[0][2] = 1'b1; ev_d[0][2] = 32'h8000_0000;
    ev_en[2][2] = 1'b1; ev_d[2][2] = 32'd1;
    set_txn(4'd3, 32'h108, 32'h0, 32'h0, 2'b01, 2'b11, 5'd5);
    run_txn("slt_dual", 1'b0);

    // destination r0: broadcast with zero data
    clr_ev();
    set_txn(4'd12, 32'h200, 32'd1, 32'd2, 2'b00, 2'b00, 5'd0);
    run_txn("r0_write", 1'b0);

    // flush beats a same-edge issue
    idle_inputs();
    issue(4'd0, 32'h0, 32'd1, 32'd1, 2'b00, 2'b00, 5'd6);
    flush_in = 1'b1;
    step();
    chk("flush_issue_busy", 32'(busy_out), 32'd0);
    chk("flush_issue_en",   32'(en_mw_out), 32'd0);
    idle_inputs();
    step();
    chk("flush_issue_en2",  32'(en_mw_out), 32'd0);

    // flush while waiting; later wakeup must not revive it
    issue(4'd0, 32'h0, 32'd1, 32'd1, 2'b11, 2'b00, 5'd6);
    step();
    idle_inputs();
    chk("flush_wait_busy0", 32'(busy_out), 32'd1);
    step();
    flush_in = 1'b1;
    step();
    chk("flush_wait_busy", 32'(busy_out), 32'd0);
    chk("flush_wait_en",   32'(en_mw_out), 32'd0);
    idle_inputs();
    en_mw2 = 1'b1; write_data2 = 32'd77;
    for (int i = 0; i < 3; i++) begin
      step();
      idle_inputs();
      chk("flush_wait_noen", 32'(en_mw_out), 32'd0);
      chk("flush_wait_idle", 32'(busy_out), 32'd0);
    end
    chk("flush_hold_data", write_data_out, last_data);

    // asynchronous reset while waiting discards the instruction
    issue(4'd0, 32'h0, 32'd1, 32'd1, 2'b01, 2'b00, 5'd9);
    step();
    idle_inputs();
    step();
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_out), 32'd0);
    chk("arst_en",   32'(en_mw_out), 32'd0);
    chk("arst_addr", 32'(reg_write_addr_out), 32'd0);
    chk("arst_data", write_data_out, 32'd0);
    last_addr = 5'd0; last_data = 32'd0;
    step();
    rst = 1'b1;
    en_mw0 = 1'b1; write_data0 = 32'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      idle_inputs();
      chk("arst_noen", 32'(en_mw_out), 32'd0);
    end

    // rdy low for three cycles during broadcast stretches it
    bc = (FWD != 0) ? 1 : 2;
    issue(4'd0, 32'h0, 32'd1, 32'd2, 2'b00, 2'b00, 5'd7);
    step();
    idle_inputs();
    for (int c = 1; c < bc; c++) step();
    chk("rdy_bcast_en", 32'(en_mw_out), 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rdy_hold_en",   32'(en_mw_out), 32'd1);
      chk("rdy_hold_data", write_data_out, 32'd3);
    end
    rdy = 1'b1;
    step();
    chk("rdy_end_en",   32'(en_mw_out), 32'd0);
    chk("rdy_end_busy", 32'(busy_out), 32'd0);
    last_addr = 5'd7; last_data = 32'd3;

    // issue during rdy low is not captured
    rdy = 1'b0;
    issue(4'd0, 32'h0, 32'd1, 32'd1, 2'b00, 2'b00, 5'd8);
    step();
    idle_inputs();
    step();
    chk("rdy_noissue_busy", 32'(busy_out), 32'd0);
    chk("rdy_noissue_en",   32'(en_mw_out), 32'd0);

    // bus event during rdy low is lost; a later one completes it
    issue(4'd0, 32'h0, 32'h0, 32'd5, 2'b11, 2'b00, 5'd9);
    step();
    idle_inputs();
    rdy = 1'b0; en_mw2 = 1'b1; write_data2 = 32'd55;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rdy_lost_en",   32'(en_mw_out), 32'd0);
      chk("rdy_lost_busy", 32'(busy_out), 32'd1);
    end
    en_mw2 = 1'b1; write_data2 = 32'd20;
    step();
    idle_inputs();
    if (FWD == 0) step();
    chk("rdy_late_en",   32'(en_mw_out), 32'd1);
    chk("rdy_late_data", write_data_out, 32'd25);
    chk("rdy_late_addr", 32'(reg_write_addr_out), 32'd9);
    last_addr = 5'd9; last_data = 32'd25;
    step();
    chk("rdy_late_done", 32'(busy_out), 32'd0);

    // randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      clr_ev();
      for (int b = 0; b < 3; b++) begin
        int k;
        k = $urandom_range(0, 4);
        ev_en[b][k] = 1'b1;
        ev_d[b][k]  = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          int k2;
          k2 = $urandom_range(k + 1, 7);
          ev_en[b][k2] = 1'b1;
          ev_d[b][k2]  = $urandom;
        end
      end
      set_txn(4'($urandom), $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      run_txn("rand", 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_station.md
ALU_STATION -- requirements
Module: alu_station

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 rdy  in  1  global enable; low freezes all state and outputs.
REQ-004 Parameter MY_TAG, default 2'b01 (ALU_MASTER): tag this station broadcasts under; second instance uses 2'b10 (ALU_SALVER).
REQ-005 en_in  in  1  issue strobe from allocator (alu0_en_out/alu1_en_out).
REQ-006 pc_in  in  32  instruction PC.
REQ-007 op_in  in  4  ALU sub-op (sinst_t).
REQ-008 tagx_in, tagy_in  in  2 each  operand tags; 2'b00 = UNLOCKED.
REQ-009 datax_in, datay_in  in  32 each  operand values, valid when tag UNLOCKED.
REQ-010 tagw_in  in  2  destination tag; carried only for debug, never alters function.
REQ-011 addrw_in  in  5  destination register.
REQ-012 en_mw0..2, write_data0..2  in  1/32 each  snooped write-back buses for tags 01 (ALU_MASTER), 10 (ALU_SALVER), 11 (LOAD_STORE).
REQ-013 flush_in  in  1  misprediction kill.
REQ-014 busy_out  out  1  station occupied.
REQ-015 en_mw_out, reg_write_addr_out, write_data_out  out  1/5/32  own write-back bus.

Function
REQ-016 States IDLE, WAIT, BCAST; busy_out = (state != IDLE).
REQ-017 IDLE: en_in=1 latches pc, op, addrw, both operands, and goes to WAIT; en_in while busy is ignored, no state corrupted.
REQ-018 Wakeup: an operand whose tag T != 00 matches a bus i with en_mwi=1 and tag(i)=T takes write_datai and becomes 00; applied both to the capture-cycle inputs and to latched operands every WAIT cycle.
REQ-019 WAIT->BCAST when both latched tags are 00: result computed and registered on that edge.
REQ-020 BCAST: en_mw_out=1 for exactly one cycle with reg_write_addr_out=addrw and write_data_out=result; next edge -> IDLE, busy_out=0.
REQ-021 addrw=0: broadcast still occurs, write_data_out forced to 0.
REQ-022 Ops (pc-relative ops use pc): 0 ADD x+y, 1 SUB x-y, 2 SLL x<<y[4:0], 3 SLT signed, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, A LUI (y), B AUIPC (pc+y), C JAL/JALR link (pc+4); D-F give 0. All arithmetic is modulo 2^32.
REQ-023 Outside BCAST, en_mw_out=0 and addr/data hold their last value.
REQ-024 flush_in=1 (rdy=1): next edge state=IDLE, en_mw_out=0; beats en_in on the same edge (issue dropped); flush during BCAST cancels the following cycle only.
REQ-025 rdy=0: no capture, no wakeup, no transition; a bus event during rdy=0 is lost.
REQ-026 Simultaneous wakeup of x and y from different buses in one cycle: both resolve.

Reset
REQ-027 rst=0: state=IDLE, busy_out=0, en_mw_out=0, reg_write_addr_out=0, write_data_out=0, latched tags=00, data=0, immediately and asynchronously.
REQ-028 Reset mid-WAIT/BCAST discards the instruction; no broadcast after release.

Configuration
REQ-029 Macro ALU_STATION_FORWARD_EN.
REQ-030 Defined: ready-at-capture or woken-this-edge operands go straight to BCAST on the same edge (issue->en_mw_out latency 1 cycle).
REQ-031 Undefined: every capture enters WAIT; the BCAST decision uses only latched tags (latency 2 cycles minimum).

Structure
REQ-032 Shared defines header holds word_t, addr_t, regtag_t, regaddr_t, sinst_t, tag constants UNLOCKED/ALU_MASTER/ALU_SALVER/LOAD_STORE and the ALU op codes.
REQ-033 One combinational sub-module alu_core (op, pc, x, y -> result); the station holds the state machine and wakeup logic.

Verification
REQ-034 FORWARD_EN, en_in op=0 x=5 y=7 tags 00 addrw=3 -> next cycle en_mw_out=1, addr 3, data 12; busy low the cycle after.
REQ-035 tagx=11, y=1, op=1; four cycles later en_mw2=1 data=10 -> BCAST data 9 the following cycle (FORWARD_EN) / two cycles after (undefined).
REQ-036 tagx=01, tagy=11 woken in the same cycle by buses 0 (0x80000000) and 2 (1), op=3 -> result 1.
REQ-037 flush_in asserted with en_in in IDLE, and again during WAIT -> no en_mw_out ever, busy_out=0 after one edge.
REQ-038 rst low during WAIT, rdy low for 3 cycles during BCAST -> outputs zero immediately; with rdy low, en_mw_out held 1 until rdy returns, then one more cycle.
